// File: rtl/wb_regfile.sv
// Writeback stage: selects the MEM/WB result, commits it to the register file, and serves two bypassed read ports.
// Latency: 0 cycles to read ports through the bypass, 1 edge to the array. No backpressure: every valid write is accepted.
module wb_regfile #(
  parameter int ASIZE = 5,
  parameter int DSIZE = 32,
  parameter int ISIZE = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] dmrdata,
  input  logic [DSIZE-1:0] aluout,
  input  logic             wen,
  input  logic             memtoreg,
  input  logic             jal,
  input  logic [ISIZE-1:0] nPC,
  input  logic [ASIZE-1:0] raddr_a,
  input  logic [ASIZE-1:0] raddr_b,
  output logic [DSIZE-1:0] rdata_a,
  output logic [DSIZE-1:0] rdata_b,
  output logic [DSIZE-1:0] wb_data,
  output logic             wb_valid,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [ASIZE-1:0] last_waddr,
  output logic [DSIZE-1:0] last_wdata
);

  localparam int DEPTH = 1 << ASIZE;

  typedef struct packed {
    logic [ASIZE-1:0] addr;
    logic [DSIZE-1:0] data;
  } commit_t;

  logic [DSIZE-1:0] regs [DEPTH];
  logic [DSIZE-1:0] link_data;
  commit_t          last_commit;

  // Link address is zero-extended or truncated to the register width.
  generate
    if (ISIZE >= DSIZE) begin : g_link_trunc
      assign link_data = nPC[DSIZE-1:0];
    end else begin : g_link_ext
      assign link_data = {{(DSIZE-ISIZE){1'b0}}, nPC};
    end
  endgenerate

  always_comb begin
    wb_data = aluout;
    if (jal) begin
      wb_data = link_data;
    end else if (memtoreg) begin
      wb_data = dmrdata;
    end
  end

  assign wb_valid = wen && (waddr != '0);

  // Bypass stays live during reset; only the commit itself is suppressed.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != '0) begin
      if (wb_valid && (raddr_a == waddr)) begin
        rdata_a = wb_data;
      end else begin
        rdata_a = regs[raddr_a];
      end
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != '0) begin
      if (wb_valid && (raddr_b == waddr)) begin
        rdata_b = wb_data;
      end else begin
        rdata_b = regs[raddr_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      retire_cnt  <= '0;
      last_commit <= '0;
    end else if (wb_valid) begin
      regs[waddr]      <= wb_data;
      retire_cnt       <= retire_cnt + 1'b1;
      last_commit.addr <= waddr;
      last_commit.data <= wb_data;
    end
  end

  assign last_waddr = last_commit.addr;
  assign last_wdata = last_commit.data;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile, checked against an array-based reference model.
module tb_wb_regfile;

  localparam int ASIZE = 5;
  localparam int DSIZE = 32;
  localparam int ISIZE = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [ASIZE-1:0] waddr;
  logic [DSIZE-1:0] dmrdata;
  logic [DSIZE-1:0] aluout;
  logic             wen;
  logic             memtoreg;
  logic             jal;
  logic [ISIZE-1:0] nPC;
  logic [ASIZE-1:0] raddr_a;
  logic [ASIZE-1:0] raddr_b;
  logic [DSIZE-1:0] rdata_a;
  logic [DSIZE-1:0] rdata_b;
  logic [DSIZE-1:0] wb_data;
  logic             wb_valid;
  logic [CNT_W-1:0] retire_cnt;
  logic [ASIZE-1:0] last_waddr;
  logic [DSIZE-1:0] last_wdata;

  wb_regfile #(.ASIZE(ASIZE), .DSIZE(DSIZE), .ISIZE(ISIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .waddr(waddr), .dmrdata(dmrdata), .aluout(aluout),
    .wen(wen), .memtoreg(memtoreg), .jal(jal), .nPC(nPC),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .wb_data(wb_data), .wb_valid(wb_valid), .retire_cnt(retire_cnt),
    .last_waddr(last_waddr), .last_wdata(last_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state as plain variables.
  logic [DSIZE-1:0] m_regs [32];
  int unsigned      m_cnt;
  logic [ASIZE-1:0] m_last_addr;
  logic [DSIZE-1:0] m_last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = 0;
    m_last_addr = '0;
    m_last_data = '0;
  endtask

  function automatic logic [DSIZE-1:0] exp_wb(input bit j, input bit mt, input logic [31:0] np,
                                             input logic [31:0] dm, input logic [31:0] alu);
    if (j) return np;
    if (mt) return dm;
    return alu;
  endfunction

  // One cycle: drive inputs, check combinational outputs, clock, check architectural state.
  task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] alu,
                      input logic [31:0] dm, input bit mt, input bit j, input logic [31:0] np,
                      input logic [4:0] ra, input logic [4:0] rb);
    logic [31:0] ewb;
    bit          ev;
    logic [31:0] ea, eb;
    rst = r; wen = w; waddr = wa; aluout = alu; dmrdata = dm;
    memtoreg = mt; jal = j; nPC = np; raddr_a = ra; raddr_b = rb;
    ewb = exp_wb(j, mt, np, dm, alu);
    ev  = w && (wa != 0);
    ea  = (ra == 0) ? 32'h0 : (ev && ra == wa) ? ewb : m_regs[ra];
    eb  = (rb == 0) ? 32'h0 : (ev && rb == wa) ? ewb : m_regs[rb];
    #1;
    chk("wb_valid", 64'(wb_valid), 64'(ev));
    chk("wb_data", 64'(wb_data), 64'(ewb));
    chk("rdata_a", 64'(rdata_a), 64'(ea));
    chk("rdata_b", 64'(rdata_b), 64'(eb));
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else if (ev) begin
      m_regs[wa]  = ewb;
      m_cnt       = m_cnt + 1;
      m_last_addr = wa;
      m_last_data = ewb;
    end
    #1;
    chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt % (1 << CNT_W)));
    chk("last_waddr", 64'(last_waddr), 64'(m_last_addr));
    chk("last_wdata", 64'(last_wdata), 64'(m_last_data));
  endtask

  task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, ra, rb);
  endtask

  initial begin
    model_reset();
    rst = 1'b0; wen = 1'b0; waddr = '0; aluout = '0; dmrdata = '0;
    memtoreg = 1'b0; jal = 1'b0; nPC = '0; raddr_a = '0; raddr_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt", 64'(retire_cnt), 64'd0);
    chk("reset_last_waddr", 64'(last_waddr), 64'd0);
    chk("reset_last_wdata", 64'(last_wdata), 64'd0);

    // Write reg5 then hold reset for two cycles.
    step(1'b1, 1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 32'h0, 5'd5, 5'd0);
    idle_read(5'd5, 5'd5);
    step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd5, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd5, 5'd0);
    idle_read(5'd5, 5'd0);
    chk("reg5_after_reset", 64'(rdata_a), 64'd0);

    // Select priority.
    step(1'b1, 1'b1, 5'd3, 32'hA, 32'hB, 1'b0, 1'b0, 32'h40, 5'd3, 5'd0);
    chk("cnt_after_alu", 64'(retire_cnt), 64'd1);
    step(1'b1, 1'b1, 5'd3, 32'hA, 32'hB, 1'b1, 1'b0, 32'h40, 5'd3, 5'd0);
    chk("cnt_after_mem", 64'(retire_cnt), 64'd2);
    step(1'b1, 1'b1, 5'd3, 32'hA, 32'hB, 1'b1, 1'b1, 32'h40, 5'd3, 5'd0);
    chk("cnt_after_jal", 64'(retire_cnt), 64'd3);
    idle_read(5'd3, 5'd3);
    chk("reg3_jal", 64'(rdata_a), 64'h40);

    // Register 0 write is ignored.
    step(1'b1, 1'b1, 5'd0, 32'hFFFF, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
    chk("reg0_cnt", 64'(retire_cnt), 64'd3);

    // Bypass on both ports.
    step(1'b1, 1'b1, 5'd7, 32'h11, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd7, 32'h22, 32'h0, 1'b0, 1'b0, 32'h0, 5'd7, 5'd7);
    idle_read(5'd7, 5'd7);
    chk("bypass_commit_a", 64'(rdata_a), 64'h22);

    // Reset beats a simultaneous write; next edge resumes.
    step(1'b0, 1'b1, 5'd9, 32'h99, 32'h0, 1'b0, 1'b0, 32'h0, 5'd9, 5'd9);
    chk("rst_vs_write_cnt", 64'(retire_cnt), 64'd0);
    idle_read(5'd9, 5'd0);
    chk("rst_vs_write_reg9", 64'(rdata_a), 64'd0);
    step(1'b1, 1'b1, 5'd9, 32'h99, 32'h0, 1'b0, 1'b0, 32'h0, 5'd9, 5'd0);
    chk("resume_cnt", 64'(retire_cnt), 64'd1);
    chk("resume_last_waddr", 64'(last_waddr), 64'd9);
    idle_read(5'd9, 5'd9);
    chk("resume_reg9", 64'(rdata_b), 64'h99);

    // Counter wrap: 17 commits from reset.
    step(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b1, 5'(1 + (i % 31)), $urandom, $urandom, 1'b0, 1'b0, 32'h0,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    chk("wrap_cnt", 64'(retire_cnt), 64'd1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] wa;
      logic [4:0] ra;
      logic [4:0] rb;
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), wa, $urandom, $urandom,
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), $urandom, ra, rb);
    end

    // Sweep the array back out.
    for (int a = 0; a < 32; a++) begin
      idle_read(5'(a), 5'(31 - a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback end of the MEM/WB interface: consumes the MEM/WB register outputs, selects the writeback value, and commits it into the architectural register file.
- Provides the two decode-stage read ports, with same-cycle write-to-read bypass.
- Exports the selected writeback value for forwarding.
- Maintains a retired-write counter and a last-commit record for debug and bench checking.

Parameters:
- ASIZE, 5: register address width; file depth 2^ASIZE.
- DSIZE, 32: register data width.
- ISIZE, 32: nPC width.
- CNT_W, 32: retired-write counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-low (reset when low, sampled on rising clk).
- waddr  in  ASIZE  destination register from MEM/WB.
- dmrdata  in  DSIZE  data-memory read data from MEM/WB.
- aluout  in  DSIZE  ALU result from MEM/WB.
- wen  in  1  register write enable from MEM/WB.
- memtoreg  in  1  1 = write dmrdata.
- jal  in  1  1 = write link value nPC.
- nPC  in  ISIZE  link address from MEM/WB.
- raddr_a  in  ASIZE  read port A address.
- raddr_b  in  ASIZE  read port B address.
- rdata_a  out  DSIZE  read port A data.
- rdata_b  out  DSIZE  read port B data.
- wb_data  out  DSIZE  selected writeback value (forwarding source).
- wb_valid  out  1  wen high and waddr nonzero (combinational).
- retire_cnt  out  CNT_W  count of committed writes.
- last_waddr  out  ASIZE  address of most recent commit.
- last_wdata  out  DSIZE  data of most recent commit.

Behaviour:
- Writeback select (combinational), priority jal > memtoreg > ALU:
  - jal=1: wb_data = nPC, zero-extended or truncated to DSIZE.
  - else memtoreg=1: wb_data = dmrdata.
  - else: wb_data = aluout.
- Commit condition: rst high, wen=1, waddr!=0.
  - On the rising edge: reg[waddr] <= wb_data; retire_cnt += 1; last_waddr <= waddr; last_wdata <= wb_data.
  - Otherwise no state changes.
- Register 0: never written, always reads 0, even when wen=1 and waddr=0. Such a write does not count and does not update the last_* record.
- Reads are combinational, per port independently:
  - raddr=0 gives 0.
  - else, if wb_valid and raddr==waddr, returns wb_data (bypass: the value being committed this cycle).
  - else returns reg[raddr].
- Both ports may read the same address. Both may hit the bypass in the same cycle.
- retire_cnt wraps from 2^CNT_W-1 to 0. No saturation and no flag.
- Reset, when rst is low at a rising edge:
  - All registers, retire_cnt, last_waddr and last_wdata go to 0.
  - Reset overrides a simultaneous commit; nothing is written.
  - Reset mid-stream takes effect on that edge; the next edge with rst high resumes normally.
- Bypass during reset: while rst is low, the read ports still apply the bypass combinationally. The write itself is discarded.
- Latency: a write committed at edge N is visible from the register array after edge N. Through the bypass it is visible in the same cycle, before edge N.
- X on memtoreg, jal, nPC or dmrdata is don't-care when wen=0.

Test Plan:
- Reset: rst=0 for 2 cycles after writing reg 5 = 0x1234 -> rdata_a(raddr=5)=0, retire_cnt=0, last_waddr=0, last_wdata=0.
- Select priority:
  - wen=1, waddr=3, aluout=0xA, memtoreg=0, jal=0 -> reg3=0xA.
  - memtoreg=1, dmrdata=0xB -> reg3=0xB.
  - jal=1, memtoreg=1, nPC=0x40 -> reg3=0x40.
  - Each commit increments retire_cnt: 1, 2, 3.
- Register 0: wen=1, waddr=0, aluout=0xFFFF -> rdata_a(raddr=0)=0, wb_valid=0, retire_cnt unchanged.
- Bypass: reg7 holds 0x11; same cycle wen=1, waddr=7, aluout=0x22, raddr_a=raddr_b=7 -> rdata_a=rdata_b=0x22 before the edge; after the edge with wen=0, both read 0x22.
- Reset vs write: rst=0 with wen=1, waddr=9, aluout=0x99 -> after the edge reg9=0 and retire_cnt=0. Next cycle rst=1 with the same write -> reg9=0x99, retire_cnt=1, last_waddr=9.
- Wrap: with CNT_W=4, perform 17 valid commits -> retire_cnt=1.
